msrv32_imem_slave: RTL and testbench

Instruction-memory responder on the fetch bus driven by the PC stage. It samples the PC stage's registered instruction address and returns the 32-bit instruction word. It drives the AHB-style ready back to the core and supports configurable wait states and a two-cycle error response. It holds a synchronous word array that a side-band load port fills before or between fetches.

---
 rtl/msrv32_bus_pkg.sv | 34 +++
 rtl/msrv32_imem_ram.sv | 38 +++
 rtl/msrv32_imem_slave.sv | 139 +++++++++++++
 tb/tb_msrv32_imem_slave.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_bus_pkg.sv
// +--------------------------------------------------------------------------+
// | Module   : msrv32_bus_pkg                                                 |
// | Brief    : Fetch-bus response codes, imem FSM encoding, address helper.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

package msrv32_bus_pkg;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef logic [2:0] imem_state_t;

  localparam imem_state_t ST_IDLE = 3'd0;
  localparam imem_state_t ST_WAIT = 3'd1;
  localparam imem_state_t ST_DATA = 3'd2;
  localparam imem_state_t ST_ERR1 = 3'd3;
  localparam imem_state_t ST_ERR2 = 3'd4;

  // Addresses below base wrap to a huge offset and so fail the range test.
  function automatic logic word_addr_ok(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input int unsigned depth_words);
    logic [31:0] offset;
    offset = addr - base;
    return (addr[1:0] == 2'b00) && (offset < (depth_words << 2));
  endfunction

endpackage

`default_nettype wire

// File: rtl/msrv32_imem_ram.sv
// +--------------------------------------------------------------------------+
// | Module   : msrv32_imem_ram                                                |
// | Brief    : Synchronous word array, registered read, read-before-write.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module msrv32_imem_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             i_rd_en,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [31:0]      o_rd_data,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [31:0]      i_wr_data
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rd_data;

  // A same-index write on the read edge lands after the old word is captured.
  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_idx];
    end
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/msrv32_imem_slave.sv
// +--------------------------------------------------------------------------+
// | Module   : msrv32_imem_slave                                              |
// | Brief    : Fetch-bus instruction memory with wait states and 2-cycle      |
// |            error response, plus a side-band load port.                   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module msrv32_imem_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        i_req_in,
  input  logic [31:0] i_addr_in,
  output logic [31:0] instr_out,
  output logic        ahb_ready_out,
  output logic        ahb_resp_out,
  input  logic        load_en_in,
  input  logic [31:0] load_addr_in,
  input  logic [31:0] load_data_in
);

  import msrv32_bus_pkg::*;

  localparam int unsigned c_idx_w     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  c_wait_load = 4'(WAIT_STATES);
  localparam logic        c_no_wait   = (WAIT_STATES == 0);

  imem_state_t        r_state;
  imem_state_t        w_state_nxt;
  logic [3:0]         r_wait_cnt;
  logic [3:0]         w_wait_cnt_nxt;
  logic [c_idx_w-1:0] r_index;
  logic               r_nop_sel;

  logic               w_ready;
  logic               w_accept;
  logic               w_fetch_ok;
  logic               w_ld_ok;
  logic               w_rd_en;
  logic [c_idx_w-1:0] w_fetch_idx;
  logic [c_idx_w-1:0] w_ld_idx;
  logic [c_idx_w-1:0] w_rd_idx;
  logic [31:0]        w_rd_data;

  assign w_fetch_idx = c_idx_w'((i_addr_in - BASE_ADDR) >> 2);
  assign w_ld_idx    = c_idx_w'((load_addr_in - BASE_ADDR) >> 2);
  assign w_fetch_ok  = word_addr_ok(i_addr_in, BASE_ADDR, DEPTH_WORDS);
  assign w_ld_ok     = load_en_in && word_addr_ok(load_addr_in, BASE_ADDR, DEPTH_WORDS);

  assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2);
  assign w_accept = i_req_in && w_ready;

  // With no wait states the read must use the live address to hit the next cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_rd_en        = 1'b0;
    w_rd_idx       = r_index;
    case (r_state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        w_state_nxt = ST_IDLE;
        w_rd_idx    = w_fetch_idx;
        if (w_accept) begin
          if (!w_fetch_ok) begin
            w_state_nxt = ST_ERR1;
          end else if (c_no_wait) begin
            w_state_nxt = ST_DATA;
            w_rd_en     = 1'b1;
          end else begin
            w_state_nxt    = ST_WAIT;
            w_wait_cnt_nxt = c_wait_load;
          end
        end
      end
      ST_WAIT: begin
        w_wait_cnt_nxt = r_wait_cnt - 4'd1;
        if (r_wait_cnt <= 4'd1) begin
          w_state_nxt    = ST_DATA;
          w_wait_cnt_nxt = 4'd0;
          w_rd_en        = 1'b1;
        end
      end
      ST_ERR1: begin
        w_state_nxt = ST_ERR2;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
      r_nop_sel  <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_state_nxt == ST_ERR1) begin
        r_nop_sel <= 1'b1;
      end else if (w_rd_en) begin
        r_nop_sel <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_accept) begin
      r_index <= w_fetch_idx;
    end
  end

  msrv32_imem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (c_idx_w)
  ) u_ram (
    .clk       (clk_in),
    .i_rd_en   (w_rd_en && !rst_in),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data),
    .i_wr_en   (w_ld_ok),
    .i_wr_idx  (w_ld_idx),
    .i_wr_data (load_data_in)
  );

  // The RAM output register holds between reads, so instr_out holds too.
  assign instr_out     = r_nop_sel ? NOP_INSTR : w_rd_data;
  assign ahb_ready_out = w_ready;
  assign ahb_resp_out  = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;

endmodule

`default_nettype wire

// File: tb/tb_msrv32_imem_slave.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_msrv32_imem_slave                                           |
// | Brief    : Self-checking bench: two instances (no-wait / 2-wait, offset   |
// |            base) against a schedule-based reference model.               |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_msrv32_imem_slave;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_0100;
  localparam int          WS0   = 0;
  localparam int          WS1   = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  localparam logic [1:0] K_HOLD = 2'd0;
  localparam logic [1:0] K_DATA = 2'd1;
  localparam logic [1:0] K_NOP  = 2'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, ld_en;
  logic [31:0] addr, ld_addr, ld_data;
  logic [31:0] instr0, instr1;
  logic        ready0, ready1, resp0, resp1;

  msrv32_imem_slave #(
    .DEPTH_WORDS (DEPTH), .BASE_ADDR (BASE0), .WAIT_STATES (WS0), .NOP_INSTR (NOP)
  ) u_dut0 (
    .clk_in (clk), .rst_in (rst), .i_req_in (req), .i_addr_in (addr),
    .instr_out (instr0), .ahb_ready_out (ready0), .ahb_resp_out (resp0),
    .load_en_in (ld_en), .load_addr_in (ld_addr), .load_data_in (ld_data)
  );

  msrv32_imem_slave #(
    .DEPTH_WORDS (DEPTH), .BASE_ADDR (BASE1), .WAIT_STATES (WS1), .NOP_INSTR (NOP)
  ) u_dut1 (
    .clk_in (clk), .rst_in (rst), .i_req_in (req), .i_addr_in (addr),
    .instr_out (instr1), .ahb_ready_out (ready1), .ahb_resp_out (resp1),
    .load_en_in (ld_en), .load_addr_in (ld_addr), .load_data_in (ld_data)
  );

  // Reference model: each accepted fetch schedules its future bus cycles.
  typedef struct packed {
    logic       ready;
    logic       resp;
    logic [1:0] kind;
    logic [7:0] idx;
  } beat_t;

  logic [31:0] mmem [2][DEPTH];
  beat_t       sched [2][16];
  int          slen [2];
  logic        cur_ready [2];
  logic        cur_resp [2];
  logic [31:0] cur_instr [2];

  int checks = 0;
  int errors = 0;

  task automatic push(input int k, input logic r, input logic s, input logic [1:0] kd,
                      input logic [7:0] ix);
    beat_t b;
    b.ready = r; b.resp = s; b.kind = kd; b.idx = ix;
    sched[k][slen[k]] = b;
    slen[k]++;
  endtask

  task automatic model_edge(input int k, input int ws, input logic [31:0] base);
    beat_t       nb;
    logic [31:0] off;
    if (rst) begin
      slen[k]      = 0;
      cur_ready[k] = 1'b1;
      cur_resp[k]  = 1'b0;
      cur_instr[k] = NOP;
    end else begin
      if (req && cur_ready[k]) begin
        off = addr - base;
        if (addr[1:0] != 2'b00 || off >= 32'(4 * DEPTH)) begin
          push(k, 1'b0, 1'b1, K_NOP, 8'd0);
          push(k, 1'b1, 1'b1, K_NOP, 8'd0);
        end else begin
          for (int j = 0; j < ws; j++) push(k, 1'b0, 1'b0, K_HOLD, 8'd0);
          push(k, 1'b1, 1'b0, K_DATA, 8'(off >> 2));
        end
      end
      if (slen[k] > 0) begin
        nb = sched[k][0];
        for (int j = 0; j < slen[k] - 1; j++) sched[k][j] = sched[k][j+1];
        slen[k]--;
      end else begin
        nb.ready = 1'b1; nb.resp = 1'b0; nb.kind = K_HOLD; nb.idx = 8'd0;
      end
      cur_ready[k] = nb.ready;
      cur_resp[k]  = nb.resp;
      if (nb.kind == K_DATA) cur_instr[k] = mmem[k][nb.idx];
      else if (nb.kind == K_NOP) cur_instr[k] = NOP;
    end
    off = ld_addr - base;
    if (ld_en && ld_addr[1:0] == 2'b00 && off < 32'(4 * DEPTH)) mmem[k][off >> 2] = ld_data;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic q, input logic [31:0] a,
                      input logic le, input logic [31:0] la, input logic [31:0] ld);
    rst = r; req = q; addr = a; ld_en = le; ld_addr = la; ld_data = ld;
    @(posedge clk);
    model_edge(0, WS0, BASE0);
    model_edge(1, WS1, BASE1);
    #1;
    check("m0_ready", 32'(ready0), 32'(cur_ready[0]));
    check("m0_resp",  32'(resp0),  32'(cur_resp[0]));
    check("m0_instr", instr0,      cur_instr[0]);
    check("m1_ready", 32'(ready1), 32'(cur_ready[1]));
    check("m1_resp",  32'(resp1),  32'(cur_resp[1]));
    check("m1_instr", instr1,      cur_instr[1]);
  endtask

  typedef struct {
    logic        rst, req;
    logic [31:0] addr;
    logic        ld_en;
    logic [31:0] ld_addr, ld_data;
    logic        e_ready, e_resp;
    logic [31:0] e_instr;
  } vec_t;

  function automatic vec_t mkv(input logic r, input logic q, input logic [31:0] a,
                               input logic le, input logic [31:0] la, input logic [31:0] ld,
                               input logic er, input logic es, input logic [31:0] ei);
    vec_t v;
    v.rst = r; v.req = q; v.addr = a; v.ld_en = le; v.ld_addr = la; v.ld_data = ld;
    v.e_ready = er; v.e_resp = es; v.e_instr = ei;
    return v;
  endfunction

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    case ($urandom_range(0, 7))
      0, 1:    a = 32'(4 * $urandom_range(0, DEPTH - 1));
      2, 3:    a = BASE1 + 32'(4 * $urandom_range(0, DEPTH - 1));
      4:       a = BASE1 + 32'($urandom_range(0, 63)) | 32'h1;
      5:       a = ($urandom_range(0, 1) != 0) ? 32'h40 : 32'h140;
      6:       a = 32'h0000_00FC;
      default: a = $urandom & 32'hFFFF_FFFC;
    endcase
    return a;
  endfunction

  localparam logic [31:0] W0 = 32'h0050_0093;
  localparam logic [31:0] W1 = 32'h00A0_0113;
  localparam logic [31:0] W2 = 32'h00F0_0193;
  localparam logic [31:0] W3 = 32'h0140_0213;
  localparam logic [31:0] WA = 32'h0DEA_D0B3;
  localparam logic [31:0] WB = 32'h0BEE_F133;

  vec_t tbl [22];

  initial begin
    // Expectations refer to the no-wait instance at base 0 (16 words -> limit 0x40).
    tbl[0]  = mkv(1, 0, 32'h0,  0, 32'h0,  32'h0, 1, 0, NOP);
    tbl[1]  = mkv(0, 0, 32'h0,  1, 32'h0,  W0,    1, 0, NOP);
    tbl[2]  = mkv(0, 1, 32'h0,  1, 32'h4,  W1,    1, 0, W0);
    tbl[3]  = mkv(0, 0, 32'h0,  1, 32'h8,  W2,    1, 0, W0);
    tbl[4]  = mkv(0, 0, 32'h0,  1, 32'hC,  W3,    1, 0, W0);
    tbl[5]  = mkv(0, 1, 32'h0,  0, 32'h0,  32'h0, 1, 0, W0);
    tbl[6]  = mkv(0, 1, 32'h4,  0, 32'h0,  32'h0, 1, 0, W1);
    tbl[7]  = mkv(0, 1, 32'h8,  0, 32'h0,  32'h0, 1, 0, W2);
    tbl[8]  = mkv(0, 1, 32'hC,  0, 32'h0,  32'h0, 1, 0, W3);
    tbl[9]  = mkv(0, 0, 32'h0,  0, 32'h0,  32'h0, 1, 0, W3);
    tbl[10] = mkv(0, 1, 32'h2,  0, 32'h0,  32'h0, 0, 1, NOP);
    tbl[11] = mkv(0, 1, 32'h0,  0, 32'h0,  32'h0, 1, 1, NOP);
    tbl[12] = mkv(0, 1, 32'h40, 0, 32'h0,  32'h0, 0, 1, NOP);
    tbl[13] = mkv(0, 0, 32'h0,  0, 32'h0,  32'h0, 1, 1, NOP);
    tbl[14] = mkv(0, 1, 32'h4,  0, 32'h0,  32'h0, 1, 0, W1);
    tbl[15] = mkv(0, 0, 32'h0,  1, 32'h14, WA,    1, 0, W1);
    tbl[16] = mkv(0, 1, 32'h14, 1, 32'h14, WB,    1, 0, WA);
    tbl[17] = mkv(0, 1, 32'h14, 0, 32'h0,  32'h0, 1, 0, WB);
    tbl[18] = mkv(0, 0, 32'h0,  0, 32'h0,  32'h0, 1, 0, WB);
    tbl[19] = mkv(0, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0, 1, NOP);
    tbl[20] = mkv(0, 0, 32'h0,  0, 32'h0,  32'h0, 1, 1, NOP);
    tbl[21] = mkv(0, 0, 32'h0,  0, 32'h0,  32'h0, 1, 0, NOP);

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].addr, tbl[i].ld_en, tbl[i].ld_addr, tbl[i].ld_data);
      check($sformatf("tbl%0d_ready", i), 32'(ready0), 32'(tbl[i].e_ready));
      check($sformatf("tbl%0d_resp", i),  32'(resp0),  32'(tbl[i].e_resp));
      check($sformatf("tbl%0d_instr", i), instr0,      tbl[i].e_instr);
    end

    // Fill both arrays so later fetches never return uninitialised words.
    for (int i = 0; i < DEPTH; i++) step(0, 0, 32'h0, 1, 32'(4 * i), $urandom);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 32'h0, 1, BASE1 + 32'(4 * i), $urandom);
    step(0, 0, 32'h0, 0, 32'h0, 32'h0);

    // Two wait states on instance 1; the changed address mid-wait must be ignored.
    step(0, 1, BASE1 + 32'h4, 0, 32'h0, 32'h0);
    check("ws_ready_low1", 32'(ready1), 32'h0);
    step(0, 1, BASE1 + 32'hC, 0, 32'h0, 32'h0);
    check("ws_ready_low2", 32'(ready1), 32'h0);
    step(0, 0, 32'h0, 0, 32'h0, 32'h0);
    check("ws_ready_data", 32'(ready1), 32'h1);
    check("ws_resp_data",  32'(resp1),  32'h0);
    check("ws_instr_data", instr1,      mmem[1][1]);
    step(0, 0, 32'h0, 0, 32'h0, 32'h0);

    // Reset while instance 1 sits in its wait window.
    step(0, 1, BASE1 + 32'h8, 0, 32'h0, 32'h0);
    check("rst_pre_wait", 32'(ready1), 32'h0);
    step(1, 0, 32'h0, 0, 32'h0, 32'h0);
    check("rst_ready", 32'(ready1), 32'h1);
    check("rst_resp",  32'(resp1),  32'h0);
    check("rst_instr", instr1,      NOP);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 32'h0, 0, 32'h0, 32'h0);
      check($sformatf("rst_no_late_ready%0d", i), 32'(ready1), 32'h1);
      check($sformatf("rst_no_late_instr%0d", i), instr1, NOP);
    end

    // Randomised traffic against the model.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           pick_addr(),
           ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
           pick_addr(),
           $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
